datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the lab datapath: a register file, A/B operand registers, shifter, ALU, result register C and status flags, driven by an internal micro-sequencer instead of external per-cycle load strobes. The controller issues one operation with a start pulse and receives a done pulse when write-back completes. Width, register count and PC width are generic. It sits between the instruction-decode FSM and memory/PC logic of the CPU.

---
 rtl/datapath_seq_if.sv | 43 ++++
 rtl/datapath_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// Command/status bundle between the instruction-decode controller (master)
// and the self-sequencing datapath (slave).
interface datapath_seq_if #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 8
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  logic          start;
  logic [1:0]    op;
  logic [1:0]    shift;
  logic [RW-1:0] rn;
  logic [RW-1:0] rm;
  logic [RW-1:0] rd;
  logic          asel_zero;
  logic          bsel_imm;
  logic [W-1:0]  imm;
  logic [1:0]    wb_src;
  logic          wb_en;
  logic          setflags;
  logic [W-1:0]  mdata;
  logic [PCW-1:0] pc;

  logic          busy;
  logic          done;
  logic          N;
  logic          V;
  logic          Z;
  logic [W-1:0]  out;

  modport master (
    output start, op, shift, rn, rm, rd, asel_zero, bsel_imm, imm,
           wb_src, wb_en, setflags, mdata, pc,
    input  busy, done, N, V, Z, out
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, asel_zero, bsel_imm, imm,
           wb_src, wb_en, setflags, mdata, pc,
    output busy, done, N, V, Z, out
  );
endinterface

// File: rtl/datapath_seq.sv
// Register file + A/B/C datapath with an internal micro-sequencer: one
// command per start pulse, done pulses in the write-back cycle.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; command register captured on accept
//   S_LOADA | A <- R[rn]
//   S_LOADB | B <- R[rm]
//   S_EXEC  | C <- ALU(Ain, Bin); N/V/Z updated when setflags
//   S_WB    | R[rd] <- selected source when wb_en; done high
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  datapath_seq_if.slave  bus
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [1:0]     cmd_op_q, cmd_op_d;
  logic [1:0]     cmd_shift_q, cmd_shift_d;
  logic [RW-1:0]  cmd_rn_q, cmd_rn_d;
  logic [RW-1:0]  cmd_rm_q, cmd_rm_d;
  logic [RW-1:0]  cmd_rd_q, cmd_rd_d;
  logic           cmd_asel_zero_q, cmd_asel_zero_d;
  logic           cmd_bsel_imm_q, cmd_bsel_imm_d;
  logic [W-1:0]   cmd_imm_q, cmd_imm_d;
  logic [1:0]     cmd_wb_src_q, cmd_wb_src_d;
  logic           cmd_wb_en_q, cmd_wb_en_d;
  logic           cmd_setflags_q, cmd_setflags_d;
  logic [W-1:0]   cmd_mdata_q, cmd_mdata_d;
  logic [PCW-1:0] cmd_pc_q, cmd_pc_d;

  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic           n_q, n_d;
  logic           v_q, v_d;
  logic           z_q, z_d;
  logic [W-1:0]   regs_q [NREG];
  logic [W-1:0]   regs_d [NREG];

  logic [W-1:0]   b_shift;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   alu_res;
  logic           alu_v;
  logic [W-1:0]   wb_data;

  // Shifter and ALU operate on the registered operands and latched command.
  always_comb begin
    b_shift = b_q;
    case (cmd_shift_q)
      2'b01:   b_shift = {b_q[W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[W-1:1]};
      2'b11:   b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase

    a_in = cmd_asel_zero_q ? '0 : a_q;
    b_in = cmd_bsel_imm_q ? cmd_imm_q : b_shift;

    alu_res = '0;
    alu_v   = 1'b0;
    case (cmd_op_q)
      2'b00: begin
        alu_res = a_in + b_in;
        alu_v   = (a_in[W-1] == b_in[W-1]) && (alu_res[W-1] != a_in[W-1]);
      end
      2'b01: begin
        alu_res = a_in - b_in;
        alu_v   = (a_in[W-1] != b_in[W-1]) && (alu_res[W-1] != a_in[W-1]);
      end
      2'b10:   alu_res = a_in & b_in;
      default: alu_res = ~b_in;
    endcase
  end

  always_comb begin
    case (cmd_wb_src_q)
      2'b00:   wb_data = c_q;
      2'b01:   wb_data = W'(cmd_pc_q);
      2'b10:   wb_data = cmd_imm_q;
      default: wb_data = cmd_mdata_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cmd_op_d        = cmd_op_q;
    cmd_shift_d     = cmd_shift_q;
    cmd_rn_d        = cmd_rn_q;
    cmd_rm_d        = cmd_rm_q;
    cmd_rd_d        = cmd_rd_q;
    cmd_asel_zero_d = cmd_asel_zero_q;
    cmd_bsel_imm_d  = cmd_bsel_imm_q;
    cmd_imm_d       = cmd_imm_q;
    cmd_wb_src_d    = cmd_wb_src_q;
    cmd_wb_en_d     = cmd_wb_en_q;
    cmd_setflags_d  = cmd_setflags_q;
    cmd_mdata_d     = cmd_mdata_q;
    cmd_pc_d        = cmd_pc_q;
    a_d             = a_q;
    b_d             = b_q;
    c_d             = c_q;
    n_d             = n_q;
    v_d             = v_q;
    z_d             = z_q;
    regs_d          = regs_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_op_d        = bus.op;
          cmd_shift_d     = bus.shift;
          cmd_rn_d        = bus.rn;
          cmd_rm_d        = bus.rm;
          cmd_rd_d        = bus.rd;
          cmd_asel_zero_d = bus.asel_zero;
          cmd_bsel_imm_d  = bus.bsel_imm;
          cmd_imm_d       = bus.imm;
          cmd_wb_src_d    = bus.wb_src;
          cmd_wb_en_d     = bus.wb_en;
          cmd_setflags_d  = bus.setflags;
          cmd_mdata_d     = bus.mdata;
          cmd_pc_d        = bus.pc;
          // Non-ALU write-backs skip the operand and execute steps entirely.
          state_d = (bus.wb_src == 2'b00) ? S_LOADA : S_WB;
        end
      end
      S_LOADA: begin
        a_d     = regs_q[cmd_rn_q];
        state_d = S_LOADB;
      end
      S_LOADB: begin
        b_d     = regs_q[cmd_rm_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d = alu_res;
        if (cmd_setflags_q) begin
          n_d = alu_res[W-1];
          v_d = alu_v;
          z_d = (alu_res == '0);
        end
        state_d = S_WB;
      end
      S_WB: begin
        if (cmd_wb_en_q) begin
          regs_d[cmd_rd_q] = wb_data;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_WB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cmd_op_q        <= '0;
      cmd_shift_q     <= '0;
      cmd_rn_q        <= '0;
      cmd_rm_q        <= '0;
      cmd_rd_q        <= '0;
      cmd_asel_zero_q <= 1'b0;
      cmd_bsel_imm_q  <= 1'b0;
      cmd_imm_q       <= '0;
      cmd_wb_src_q    <= '0;
      cmd_wb_en_q     <= 1'b0;
      cmd_setflags_q  <= 1'b0;
      cmd_mdata_q     <= '0;
      cmd_pc_q        <= '0;
      a_q             <= '0;
      b_q             <= '0;
      c_q             <= '0;
      n_q             <= 1'b0;
      v_q             <= 1'b0;
      z_q             <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cmd_op_q        <= cmd_op_d;
      cmd_shift_q     <= cmd_shift_d;
      cmd_rn_q        <= cmd_rn_d;
      cmd_rm_q        <= cmd_rm_d;
      cmd_rd_q        <= cmd_rd_d;
      cmd_asel_zero_q <= cmd_asel_zero_d;
      cmd_bsel_imm_q  <= cmd_bsel_imm_d;
      cmd_imm_q       <= cmd_imm_d;
      cmd_wb_src_q    <= cmd_wb_src_d;
      cmd_wb_en_q     <= cmd_wb_en_d;
      cmd_setflags_q  <= cmd_setflags_d;
      cmd_mdata_q     <= cmd_mdata_d;
      cmd_pc_q        <= cmd_pc_d;
      a_q             <= a_d;
      b_q             <= b_d;
      c_q             <= c_d;
      n_q             <= n_d;
      v_q             <= v_d;
      z_q             <= z_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.N    = n_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.out  = c_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a vector table on a 16-bit instance plus
// hand sequences for busy-start, mid-operation reset and a 32-bit instance.
module tb_datapath_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16;
  logic rst32;

  datapath_seq_if #(.W(16), .NREG(8),  .PCW(8))  bus16 ();
  datapath_seq_if #(.W(32), .NREG(16), .PCW(12)) bus32 ();

  datapath_seq #(.W(16), .NREG(8), .PCW(8)) dut16 (
    .clk   (clk),
    .reset (rst16),
    .bus   (bus16)
  );

  datapath_seq #(.W(32), .NREG(16), .PCW(12)) dut32 (
    .clk   (clk),
    .reset (rst32),
    .bus   (bus32)
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [3:0]  rd;
    logic        asel_zero;
    logic        bsel_imm;
    logic [31:0] imm;
    logic [1:0]  wb_src;
    logic        wb_en;
    logic        setflags;
    logic [31:0] mdata;
    logic [11:0] pc;
  } cmd_t;

  typedef struct {
    cmd_t        c;
    int          lat;
    logic [15:0] out;
    logic [2:0]  nvz;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t c_dir(input logic [1:0] src, input logic [3:0] rd,
                                 input logic [31:0] val, input logic we);
    cmd_t c;
    c.op = 2'b00; c.shift = 2'b00; c.rn = 4'd0; c.rm = 4'd0; c.rd = rd;
    c.asel_zero = 1'b0; c.bsel_imm = 1'b0; c.wb_src = src; c.wb_en = we;
    c.setflags = 1'b1;
    // Unselected sources carry distinct junk so a wrong mux choice shows.
    c.imm   = (src == 2'b10) ? val : 32'h0000_DEAD;
    c.mdata = (src == 2'b11) ? val : 32'hBEEF_0000;
    c.pc    = (src == 2'b01) ? val[11:0] : 12'h5A3;
    return c;
  endfunction

  function automatic cmd_t c_alu(input logic [1:0] op, input logic [1:0] sh,
                                 input logic [3:0] rn, input logic [3:0] rm,
                                 input logic [3:0] rd, input logic az,
                                 input logic bi, input logic [31:0] imm,
                                 input logic we, input logic sf);
    cmd_t c;
    c.op = op; c.shift = sh; c.rn = rn; c.rm = rm; c.rd = rd;
    c.asel_zero = az; c.bsel_imm = bi; c.imm = imm; c.wb_src = 2'b00;
    c.wb_en = we; c.setflags = sf; c.mdata = 32'h1111_2222; c.pc = 12'h777;
    return c;
  endfunction

  // Read R[r] into C without touching flags or registers: r + 0.
  function automatic cmd_t c_rd(input logic [3:0] r);
    return c_alu(2'b00, 2'b00, r, 4'd0, 4'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t mkv(input cmd_t c, input int lat,
                               input logic [15:0] o, input logic [2:0] nvz);
    vec_t v;
    v.c = c; v.lat = lat; v.out = o; v.nvz = nvz;
    return v;
  endfunction

  task automatic drive(input int which, input cmd_t c, input logic st);
    if (which == 16) begin
      bus16.start = st; bus16.op = c.op; bus16.shift = c.shift;
      bus16.rn = c.rn[2:0]; bus16.rm = c.rm[2:0]; bus16.rd = c.rd[2:0];
      bus16.asel_zero = c.asel_zero; bus16.bsel_imm = c.bsel_imm;
      bus16.imm = c.imm[15:0]; bus16.wb_src = c.wb_src; bus16.wb_en = c.wb_en;
      bus16.setflags = c.setflags; bus16.mdata = c.mdata[15:0]; bus16.pc = c.pc[7:0];
    end else begin
      bus32.start = st; bus32.op = c.op; bus32.shift = c.shift;
      bus32.rn = c.rn; bus32.rm = c.rm; bus32.rd = c.rd;
      bus32.asel_zero = c.asel_zero; bus32.bsel_imm = c.bsel_imm;
      bus32.imm = c.imm; bus32.wb_src = c.wb_src; bus32.wb_en = c.wb_en;
      bus32.setflags = c.setflags; bus32.mdata = c.mdata; bus32.pc = c.pc;
    end
  endtask

  function automatic logic get_done(input int which);
    return (which == 16) ? bus16.done : bus32.done;
  endfunction
  function automatic logic get_busy(input int which);
    return (which == 16) ? bus16.busy : bus32.busy;
  endfunction
  function automatic logic [31:0] get_out(input int which);
    return (which == 16) ? {16'h0, bus16.out} : bus32.out;
  endfunction
  function automatic logic [2:0] get_nvz(input int which);
    return (which == 16) ? {bus16.N, bus16.V, bus16.Z} : {bus32.N, bus32.V, bus32.Z};
  endfunction

  function automatic cmd_t scramble(input cmd_t c);
    cmd_t g;
    g.op = ~c.op; g.shift = ~c.shift; g.rn = ~c.rn; g.rm = ~c.rm; g.rd = ~c.rd;
    g.asel_zero = ~c.asel_zero; g.bsel_imm = ~c.bsel_imm; g.imm = ~c.imm;
    g.wb_src = ~c.wb_src; g.wb_en = ~c.wb_en; g.setflags = ~c.setflags;
    g.mdata = ~c.mdata; g.pc = ~c.pc;
    return g;
  endfunction

  // Issue one command, scramble the inputs after acceptance, and return the
  // done latency (negedges after the accepting edge) with out/flags seen then.
  task automatic run(input int which, input cmd_t c, output int lat,
                     output logic [31:0] o, output logic [2:0] nvz);
    @(negedge clk);
    drive(which, c, 1'b1);
    @(posedge clk);
    #1;
    drive(which, scramble(c), 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_done(which) && lat < 12);
    chk("busy_with_done", {31'd0, get_busy(which)}, 32'd1);
    o   = get_out(which);
    nvz = get_nvz(which);
    @(negedge clk);
    chk("idle_after_wb", {30'd0, get_busy(which), get_done(which)}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] o;
    logic [2:0]  nvz;
    int          ndone;

    rst16 = 1'b1;
    rst32 = 1'b1;
    drive(16, c_rd(4'd0), 1'b0);
    drive(32, c_rd(4'd0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst16 = 1'b0;
    rst32 = 1'b0;

    @(negedge clk);
    chk("reset_busy_done", {30'd0, bus16.busy, bus16.done}, 32'd0);
    chk("reset_out", {16'd0, bus16.out}, 32'd0);
    chk("reset_nvz", {29'd0, bus16.N, bus16.V, bus16.Z}, 32'd0);

    vecs.push_back(mkv(c_dir(2'b10, 4'd0, 32'h0005, 1'b1), 1, 16'h0000, 3'b000));
    vecs.push_back(mkv(c_dir(2'b10, 4'd1, 32'h0003, 1'b1), 1, 16'h0000, 3'b000));
    vecs.push_back(mkv(c_alu(2'b00, 2'b01, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'h000B, 3'b000));
    vecs.push_back(mkv(c_rd(4'd2), 4, 16'h000B, 3'b000));
    vecs.push_back(mkv(c_dir(2'b10, 4'd0, 32'h8000, 1'b1), 1, 16'h000B, 3'b000));
    vecs.push_back(mkv(c_alu(2'b01, 2'b00, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1), 4, 16'h7FFF, 3'b010));
    vecs.push_back(mkv(c_alu(2'b01, 2'b00, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'h0000, 3'b001));
    vecs.push_back(mkv(c_alu(2'b01, 2'b00, 4'd0, 4'd0, 4'd4, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0), 4, 16'h7FFF, 3'b001));
    vecs.push_back(mkv(c_rd(4'd4), 4, 16'h7FFF, 3'b001));
    vecs.push_back(mkv(c_alu(2'b10, 2'b00, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'h000B, 3'b000));
    vecs.push_back(mkv(c_alu(2'b11, 2'b10, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'hBFFF, 3'b100));
    vecs.push_back(mkv(c_alu(2'b00, 2'b11, 4'd2, 4'd0, 4'd7, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'hC000, 3'b100));
    vecs.push_back(mkv(c_dir(2'b11, 4'd5, 32'h1234, 1'b1), 1, 16'hC000, 3'b100));
    vecs.push_back(mkv(c_rd(4'd5), 4, 16'h1234, 3'b100));
    vecs.push_back(mkv(c_dir(2'b01, 4'd6, 32'h00A5, 1'b1), 1, 16'h1234, 3'b100));
    vecs.push_back(mkv(c_rd(4'd6), 4, 16'h00A5, 3'b100));
    vecs.push_back(mkv(c_alu(2'b00, 2'b00, 4'd3, 4'd0, 4'd7, 1'b0, 1'b1, 32'd1, 1'b1, 1'b1), 4, 16'h8000, 3'b110));
    vecs.push_back(mkv(c_dir(2'b10, 4'd1, 32'h5555, 1'b0), 1, 16'h8000, 3'b110));
    vecs.push_back(mkv(c_rd(4'd1), 4, 16'h0003, 3'b110));
    vecs.push_back(mkv(c_alu(2'b00, 2'b00, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 4, 16'h0006, 3'b000));
    vecs.push_back(mkv(c_rd(4'd1), 4, 16'h0006, 3'b000));
    vecs.push_back(mkv(c_rd(4'd7), 4, 16'h8000, 3'b000));
    vecs.push_back(mkv(c_alu(2'b01, 2'b00, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1), 4, 16'h800C, 3'b100));

    foreach (vecs[i]) begin
      run(16, vecs[i].c, lat, o, nvz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_out", i), o, {16'd0, vecs[i].out});
      chk($sformatf("vec%0d_nvz", i), {29'd0, nvz}, {29'd0, vecs[i].nvz});
    end

    // Start pulsed during LOADB with a different command must be ignored.
    @(negedge clk);
    drive(16, c_alu(2'b00, 2'b00, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0), 1'b1);
    @(posedge clk);
    #1;
    drive(16, c_dir(2'b10, 4'd3, 32'hFFFF, 1'b1), 1'b0);
    @(posedge clk);
    #1;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus16.done) ndone++;
    end
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_idle", {31'd0, bus16.busy}, 32'd0);
    run(16, c_rd(4'd2), lat, o, nvz);
    chk("busy_start_first_cmd_R2", o, 32'h0000_000C);
    run(16, c_rd(4'd3), lat, o, nvz);
    chk("busy_start_R3_untouched", o, 32'h0000_7FFF);
    chk("busy_start_flags_hold", {29'd0, nvz}, 32'd4);

    // Reset held two cycles while in EXEC aborts without write or done.
    @(negedge clk);
    drive(16, c_alu(2'b00, 2'b00, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1), 1'b1);
    @(posedge clk);
    #1;
    drive(16, c_rd(4'd0), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst16 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_mid_no_done", {31'd0, bus16.done}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst16 = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_done", {30'd0, bus16.busy, bus16.done}, 32'd0);
    chk("rst_mid_out", {16'd0, bus16.out}, 32'd0);
    chk("rst_mid_nvz", {29'd0, bus16.N, bus16.V, bus16.Z}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      run(16, c_rd(4'(r)), lat, o, nvz);
      chk($sformatf("rst_mid_R%0d", r), o, 32'd0);
    end

    // 32-bit, 16-register, 12-bit PC instance.
    run(32, c_dir(2'b01, 4'd15, 32'h0000_0ABC, 1'b1), lat, o, nvz);
    chk("w32_pc_latency", lat, 1);
    chk("w32_pc_out_unchanged", o, 32'd0);
    run(32, c_rd(4'd15), lat, o, nvz);
    chk("w32_R15", o, 32'h0000_0ABC);
    run(32, c_dir(2'b10, 4'd3, 32'h8000_0000, 1'b1), lat, o, nvz);
    run(32, c_alu(2'b00, 2'b11, 4'd15, 4'd3, 4'd4, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1), lat, o, nvz);
    chk("w32_asr_latency", lat, 4);
    chk("w32_asr_out", o, 32'hC000_0000);
    chk("w32_asr_nvz", {29'd0, nvz}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
